// File: rtl/rob_commit.sv
// rob_commit: reorder buffer for the Tomasulo core.
// Allocates entries in program order, captures CDB results out of order and retires in order.
// On retire it drives the register-file write-back port, pulses a store commit or a flush.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   allocValid/Op/Dest          issue-side allocation request
//   allocReady, allocTag        combinational accept and tail tag
//   cdbValid/Tag/Data/Mispredict  common data bus result broadcast
//   ROBwriteEnable/Data/Index   registered register-file write (strobe is a one-cycle pulse)
//   storeCommitValid/Tag        registered one-cycle pulse when a sw retires
//   flush                       registered one-cycle pulse after a mispredicted bne retires
//   count                       number of valid entries
module rob_commit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             allocValid,
  input  logic [5:0]       allocOp,
  input  logic [4:0]       allocDest,
  output logic             allocReady,
  output logic [TAG_W-1:0] allocTag,
  input  logic             cdbValid,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic [31:0]      cdbData,
  input  logic             cdbMispredict,
  output logic             ROBwriteEnable,
  output logic [31:0]      ROBwriteData,
  output logic [4:0]       ROBwriteIndex,
  output logic             storeCommitValid,
  output logic [TAG_W-1:0] storeCommitTag,
  output logic             flush,
  output logic [TAG_W:0]   count
);

  localparam logic [5:0]   OpMaxAlu = 6'd6;
  localparam logic [5:0]   OpSw     = 6'd7;
  localparam logic [5:0]   OpBne    = 6'd8;
  localparam logic [5:0]   OpLi     = 6'd9;
  localparam logic [TAG_W:0]   Depth = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PtrOne = TAG_W'(1);

  logic [DEPTH-1:0] r_valid, r_done, r_mis;
  logic [5:0]       r_op    [DEPTH];
  logic [4:0]       r_dest  [DEPTH];
  logic [31:0]      r_value [DEPTH];

  logic [TAG_W-1:0] r_head, r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_we, r_sc, r_flush;
  logic [31:0]      r_wdata;
  logic [4:0]       r_widx;
  logic [TAG_W-1:0] r_sct;

  logic           w_cooldown, w_retire, w_flush_now, w_alloc, w_cdb_hit;
  logic           w_reg_write, w_store, w_full;
  logic [5:0]     w_head_op;
  logic [TAG_W:0] w_count_next;

  always_comb begin
    // The register file is edge-triggered on the strobe, so nothing retires while it is high.
    w_cooldown   = r_we;
    w_head_op    = r_op[r_head];
    w_retire     = r_valid[r_head] && r_done[r_head] && !w_cooldown;
    w_flush_now  = w_retire && (w_head_op == OpBne) && r_mis[r_head];
    // Full is judged on the pre-retire count: a full ROB never allocs and retires together.
    w_full       = (r_count == Depth);
    allocReady   = !w_full && !w_flush_now;
    allocTag     = r_tail;
    w_alloc      = allocValid && allocReady;
    w_reg_write  = w_retire && ((w_head_op <= OpMaxAlu) || (w_head_op == OpLi)) &&
                   (r_dest[r_head] != 5'd0);
    w_store      = w_retire && (w_head_op == OpSw);
    // Allocation of the same tag wins over a CDB write.
    w_cdb_hit    = cdbValid && r_valid[cdbTag] && !r_done[cdbTag] &&
                   !(w_alloc && (cdbTag == r_tail));
    w_count_next = r_count + {{TAG_W{1'b0}}, w_alloc} - {{TAG_W{1'b0}}, w_retire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_done  <= '0;
      r_mis   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_op[i]    <= '0;
        r_dest[i]  <= '0;
        r_value[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_widx  <= '0;
      r_sc    <= 1'b0;
      r_sct   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_we    <= w_reg_write;
      r_sc    <= w_store;
      r_flush <= w_flush_now;
      if (w_reg_write) begin
        r_widx  <= r_dest[r_head];
        r_wdata <= r_value[r_head];
      end
      if (w_store) begin
        r_sct <= r_head;
      end
      if (w_flush_now) begin
        // Mispredict squashes everything, including this cycle's alloc and CDB write.
        r_valid <= '0;
        r_done  <= '0;
        r_mis   <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_cdb_hit) begin
          r_done[cdbTag]  <= 1'b1;
          r_value[cdbTag] <= cdbData;
          r_mis[cdbTag]   <= cdbMispredict;
        end
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_done[r_head]  <= 1'b0;
          r_mis[r_head]   <= 1'b0;
          r_head          <= r_head + PtrOne;
        end
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_mis[r_tail]   <= 1'b0;
          r_op[r_tail]    <= allocOp;
          r_dest[r_tail]  <= allocDest;
          r_tail          <= r_tail + PtrOne;
        end
        r_count <= w_count_next;
      end
    end
  end

  assign ROBwriteEnable   = r_we;
  assign ROBwriteData     = r_wdata;
  assign ROBwriteIndex    = r_widx;
  assign storeCommitValid = r_sc;
  assign storeCommitTag   = r_sct;
  assign flush            = r_flush;
  assign count            = r_count;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        allocValid;
  logic [5:0]  allocOp;
  logic [4:0]  allocDest;
  logic        allocReady;
  logic [2:0]  allocTag;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [31:0] cdbData;
  logic        cdbMispredict;
  logic        ROBwriteEnable;
  logic [31:0] ROBwriteData;
  logic [4:0]  ROBwriteIndex;
  logic        storeCommitValid;
  logic [2:0]  storeCommitTag;
  logic        flush;
  logic [3:0]  count;

  rob_commit #(.DEPTH(8), .TAG_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .allocValid       (allocValid),
    .allocOp          (allocOp),
    .allocDest        (allocDest),
    .allocReady       (allocReady),
    .allocTag         (allocTag),
    .cdbValid         (cdbValid),
    .cdbTag           (cdbTag),
    .cdbData          (cdbData),
    .cdbMispredict    (cdbMispredict),
    .ROBwriteEnable   (ROBwriteEnable),
    .ROBwriteData     (ROBwriteData),
    .ROBwriteIndex    (ROBwriteIndex),
    .storeCommitValid (storeCommitValid),
    .storeCommitTag   (storeCommitTag),
    .flush            (flush),
    .count            (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: the ROB is a program-ordered queue; tags are handed out round-robin.
  typedef struct {
    logic [2:0]  tag;
    logic [5:0]  op;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] val;
    bit          mis;
  } ent_t;

  ent_t        m_q[$];
  int          m_tail = 0;
  bit          m_we = 0, m_sc = 0, m_fl = 0;
  logic [4:0]  m_idx = 0;
  logic [31:0] m_data = 0;
  logic [2:0]  m_sct = 0;

  // Values sampled before (p_) and after (q_) each clock edge.
  logic        p_rdy;
  logic [2:0]  p_tag;
  logic [3:0]  p_cnt;
  logic        q_we, q_sc, q_fl;
  logic [4:0]  q_idx;
  logic [31:0] q_data;
  logic [2:0]  q_sct;

  task automatic do_cycle(input bit rst, input bit av, input logic [5:0] op,
                          input logic [4:0] dst, input bit cv, input logic [2:0] ct,
                          input logic [31:0] cd, input bit cm);
    bit   e_commit, e_cf, e_rdy, do_alloc;
    int   e_cnt;
    ent_t h;
    reset = rst; allocValid = av; allocOp = op; allocDest = dst;
    cdbValid = cv; cdbTag = ct; cdbData = cd; cdbMispredict = cm;
    #1;
    p_rdy = allocReady; p_tag = allocTag; p_cnt = count;
    e_cnt    = m_q.size();
    e_commit = (e_cnt > 0) && m_q[0].done && !m_we;
    e_cf     = e_commit && (m_q[0].op == 6'd8) && m_q[0].mis;
    e_rdy    = (e_cnt < 8) && !e_cf;
    if (!rst) begin
      check("m_allocReady", 32'(p_rdy), 32'(e_rdy));
      check("m_allocTag", 32'(p_tag), 32'(m_tail));
      check("m_count", 32'(p_cnt), 32'(e_cnt));
    end
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_tail = 0;
      m_we = 0; m_idx = 0; m_data = 0; m_sc = 0; m_sct = 0; m_fl = 0;
    end else begin
      do_alloc = av && e_rdy;
      m_we = 0; m_sc = 0; m_fl = 0;
      if (e_cf) begin
        m_fl = 1; m_q.delete(); m_tail = 0;
      end else begin
        if (cv && !(do_alloc && ct == 3'(m_tail))) begin
          foreach (m_q[i]) begin
            if (m_q[i].tag == ct && !m_q[i].done) begin
              m_q[i].done = 1; m_q[i].val = cd; m_q[i].mis = cm;
            end
          end
        end
        if (e_commit) begin
          h = m_q.pop_front();
          if (h.op == 6'd7) begin
            m_sc = 1; m_sct = h.tag;
          end else if ((h.op <= 6'd6 || h.op == 6'd9) && h.dest != 5'd0) begin
            m_we = 1; m_idx = h.dest; m_data = h.val;
          end
        end
        if (do_alloc) begin
          m_q.push_back('{tag: 3'(m_tail), op: op, dest: dst, done: 0, val: 0, mis: 0});
          m_tail = (m_tail + 1) % 8;
        end
      end
    end
    #1;
    q_we = ROBwriteEnable; q_idx = ROBwriteIndex; q_data = ROBwriteData;
    q_sc = storeCommitValid; q_sct = storeCommitTag; q_fl = flush;
    check("m_ROBwriteEnable", 32'(q_we), 32'(m_we));
    check("m_ROBwriteIndex", 32'(q_idx), 32'(m_idx));
    check("m_ROBwriteData", q_data, m_data);
    check("m_storeCommitValid", 32'(q_sc), 32'(m_sc));
    if (m_sc) check("m_storeCommitTag", 32'(q_sct), 32'(m_sct));
    check("m_flush", 32'(q_fl), 32'(m_fl));
  endtask

  task automatic idle();
    do_cycle(0, 0, 6'd0, 5'd0, 0, 3'd0, 32'd0, 0);
  endtask

  task automatic do_reset();
    do_cycle(1, 0, 6'd0, 5'd0, 0, 3'd0, 32'd0, 0);
  endtask

  typedef struct {
    bit          av;
    logic [5:0]  op;
    logic [4:0]  dst;
    bit          cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    bit          cm;
    bit          rdy;
    logic [2:0]  tag;
    logic [3:0]  cnt;
    bit          we;
    logic [4:0]  idx;
    logic [31:0] data;
    bit          sc;
    logic [2:0]  sct;
    bit          fl;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Idle, single addi, out-of-order pair, then sw + add r0.
    vecs = '{
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd0, 4'd0,  0, 5'd0, 32'h00, 0, 3'd0, 0},
      '{1, 6'd1, 5'd5, 0, 3'd0, 32'h00, 0,  1, 3'd0, 4'd0,  0, 5'd0, 32'h00, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 1, 3'd0, 32'h2A, 0,  1, 3'd1, 4'd1,  0, 5'd0, 32'h00, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd1, 4'd1,  1, 5'd5, 32'h2A, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd1, 4'd0,  0, 5'd5, 32'h2A, 0, 3'd0, 0},
      '{1, 6'd0, 5'd1, 0, 3'd0, 32'h00, 0,  1, 3'd1, 4'd0,  0, 5'd5, 32'h2A, 0, 3'd0, 0},
      '{1, 6'd0, 5'd2, 0, 3'd0, 32'h00, 0,  1, 3'd2, 4'd1,  0, 5'd5, 32'h2A, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 1, 3'd2, 32'h07, 0,  1, 3'd3, 4'd2,  0, 5'd5, 32'h2A, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 1, 3'd1, 32'h09, 0,  1, 3'd3, 4'd2,  0, 5'd5, 32'h2A, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd3, 4'd2,  1, 5'd1, 32'h09, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd3, 4'd1,  0, 5'd1, 32'h09, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd3, 4'd1,  1, 5'd2, 32'h07, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd3, 4'd0,  0, 5'd2, 32'h07, 0, 3'd0, 0},
      '{1, 6'd7, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd3, 4'd0,  0, 5'd2, 32'h07, 0, 3'd0, 0},
      '{1, 6'd0, 5'd0, 1, 3'd3, 32'h11, 0,  1, 3'd4, 4'd1,  0, 5'd2, 32'h07, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 1, 3'd4, 32'h05, 0,  1, 3'd5, 4'd2,  0, 5'd2, 32'h07, 1, 3'd3, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd5, 4'd1,  0, 5'd2, 32'h07, 0, 3'd0, 0},
      '{0, 6'd0, 5'd0, 0, 3'd0, 32'h00, 0,  1, 3'd5, 4'd0,  0, 5'd2, 32'h07, 0, 3'd0, 0}
    };

    reset = 1; allocValid = 0; allocOp = 0; allocDest = 0;
    cdbValid = 0; cdbTag = 0; cdbData = 0; cdbMispredict = 0;
    @(posedge clk); #1;
    do_reset();
    do_reset();
    check("reset_we", 32'(ROBwriteEnable), 32'd0);
    check("reset_count", 32'(count), 32'd0);

    for (int i = 0; i < 18; i++) begin
      do_cycle(0, vecs[i].av, vecs[i].op, vecs[i].dst, vecs[i].cv, vecs[i].ct,
               vecs[i].cd, vecs[i].cm);
      check($sformatf("v%0d_allocReady", i), 32'(p_rdy), 32'(vecs[i].rdy));
      check($sformatf("v%0d_allocTag", i), 32'(p_tag), 32'(vecs[i].tag));
      check($sformatf("v%0d_count", i), 32'(p_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d_we", i), 32'(q_we), 32'(vecs[i].we));
      check($sformatf("v%0d_idx", i), 32'(q_idx), 32'(vecs[i].idx));
      check($sformatf("v%0d_data", i), q_data, vecs[i].data);
      check($sformatf("v%0d_sc", i), 32'(q_sc), 32'(vecs[i].sc));
      if (vecs[i].sc) check($sformatf("v%0d_sct", i), 32'(q_sct), 32'(vecs[i].sct));
      check($sformatf("v%0d_flush", i), 32'(q_fl), 32'(vecs[i].fl));
    end

    // Full and wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_cycle(0, 1, 6'd0, 5'(i + 1), 0, 3'd0, 32'd0, 0);
      check("full_fill_tag", 32'(p_tag), 32'(i));
    end
    do_cycle(0, 1, 6'd0, 5'd20, 1, 3'd0, 32'h100, 0);
    check("full_ready", 32'(p_rdy), 32'd0);
    check("full_count", 32'(p_cnt), 32'd8);
    do_cycle(0, 1, 6'd0, 5'd21, 0, 3'd0, 32'd0, 0);
    check("full_retire_ready", 32'(p_rdy), 32'd0);
    check("full_retire_count", 32'(p_cnt), 32'd8);
    check("full_retire_we", 32'(q_we), 32'd1);
    check("full_retire_idx", 32'(q_idx), 32'd1);
    do_cycle(0, 1, 6'd0, 5'd9, 0, 3'd0, 32'd0, 0);
    check("wrap_ready", 32'(p_rdy), 32'd1);
    check("wrap_tag", 32'(p_tag), 32'd0);
    check("wrap_count_before", 32'(p_cnt), 32'd7);
    idle();
    check("wrap_count_after", 32'(p_cnt), 32'd8);

    // Mispredicted bne flushes a completed younger add.
    do_reset();
    do_cycle(0, 1, 6'd8, 5'd0, 0, 3'd0, 32'd0, 0);
    do_cycle(0, 1, 6'd0, 5'd3, 0, 3'd0, 32'd0, 0);
    do_cycle(0, 0, 6'd0, 5'd0, 1, 3'd1, 32'h33, 0);
    do_cycle(0, 0, 6'd0, 5'd0, 1, 3'd0, 32'h0, 1);
    do_cycle(0, 1, 6'd0, 5'd4, 0, 3'd0, 32'd0, 0);
    check("flush_alloc_ready", 32'(p_rdy), 32'd0);
    check("flush_pulse", 32'(q_fl), 32'd1);
    check("flush_no_write", 32'(q_we), 32'd0);
    idle();
    check("flush_count", 32'(p_cnt), 32'd0);
    check("flush_tag", 32'(p_tag), 32'd0);
    check("flush_single_pulse", 32'(q_fl), 32'd0);
    check("flush_no_write_r3", 32'(q_we), 32'd0);

    // Reset overrides a pending retire.
    do_reset();
    do_cycle(0, 1, 6'd1, 5'd7, 0, 3'd0, 32'd0, 0);
    do_cycle(0, 0, 6'd0, 5'd0, 1, 3'd0, 32'h55, 0);
    do_reset();
    check("midreset_we", 32'(q_we), 32'd0);
    idle();
    check("midreset_count", 32'(p_cnt), 32'd0);
    check("midreset_idx", 32'(q_idx), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit          rst, av, cv, cm;
      logic [5:0]  op;
      logic [4:0]  dst;
      logic [2:0]  ct;
      rst = ($urandom % 400) == 0;
      av  = ($urandom % 10) < 6;
      op  = 6'($urandom_range(0, 9));
      dst = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cv  = ($urandom % 2) == 1;
      if (m_q.size() > 0 && ($urandom % 4) != 0) ct = m_q[$urandom_range(0, m_q.size() - 1)].tag;
      else ct = 3'($urandom);
      cm  = ($urandom % 4) == 0;
      do_cycle(rst, av, op, dst, cv, ct, $urandom, cm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
